fm0_encoder: RTL and testbench
==============================

Name: fm0_encoder

Overview:
- Tag uplink backscatter encoder; sits directly downstream of the clock divider and consumes its `clk_div` output as the half-bit-rate reference.
- Serialises a captured data word into an FM0 waveform, framed as:
  - optional pilot tone
  - Gen2-style FM0 preamble
  - data, MSB first
  - trailing dummy-1 bit
- Drives the backscatter modulator through `tx_out` and `tx_en`.

Parameters:
- MAX_BITS, 32, maximum number of data bits per frame; width of `data_in`.
- CNT_W, 6, width of `bit_count`; must satisfy 2^CNT_W > MAX_BITS.

Ports:
- clock  input  1  system clock; the divider runs on the same clock.
- reset  input  1  synchronous, active-high reset.
- clk_div  input  1  divider output; every toggle is one half-bit strobe.
- start  input  1  single-clock request to begin a frame.
- data_in  input  MAX_BITS  payload; bit `bit_count-1` is sent first.
- bit_count  input  CNT_W  number of data bits to send; values above MAX_BITS are clamped to MAX_BITS.
- trext  input  1  pilot tone request; honoured only when PILOT_TONE_EN is defined.
- busy  output  1  high from start acceptance until frame end.
- tx_en  output  1  high while the frame waveform is driven.
- tx_out  output  1  FM0 line level.
- done  output  1  one-clock pulse after the dummy bit completes.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - busy, tx_en, tx_out, done = 0.
  - clk_div_q = 1, matching the divider's reset level, so no spurious tick occurs after reset.
  - state = IDLE.
  - All counters = 0.
- Half-bit tick: `clk_div_q` is registered every clock. tick = (clk_div != clk_div_q). Both edges of clk_div count, so each tick is one half-bit (10 clocks when the divider toggles at count 9).
- Stall: if the divider is disabled, clk_div freezes and no ticks occur. The encoder holds state and all outputs indefinitely.
- States: IDLE, WAIT, PILOT, PREAMBLE, DATA, DUMMY.
- IDLE:
  - On `start`: capture data_in and the clamped bit_count, set busy=1, go to WAIT.
  - `start` is ignored in every other state.
  - Input changes after capture have no effect.
- WAIT:
  - On the next tick, go to PILOT if pilot is active, else PREAMBLE.
  - tx_en=1 from that same edge.
- Output timing: every tx_out change occurs on the clock edge where tick=1, i.e. one clock after clk_div toggles. Each state consumes whole half-bits.
- PILOT: 24 half-bits of alternating levels, starting high (H L H L …, ends L). Equivalent to 12 FM0 data-0 bits.
- PREAMBLE: 12 half-bits, MSB first, from constant `110100100011`. The level ends high.
- FM0 encoding rule (DATA and DUMMY):
  - The level inverts at every bit boundary relative to the previous half-bit.
  - A data-0 additionally inverts at mid-bit; a data-1 holds for both halves.
- DATA:
  - Sends the captured bit_count bits MSB first.
  - If bit_count = 0, go straight from PREAMBLE to DUMMY.
- DUMMY: one data-1 bit (two half-bits).
- Frame end:
  - On the tick ending the dummy bit: tx_en=0, tx_out=0, busy=0, done=1 for exactly one clock, then IDLE.
  - A new start is accepted on the clock after done.
- Reset mid-frame: the next clock has all outputs at reset values and state IDLE. No done pulse is produced.
- Start and tick on the same clock in IDLE: capture only. The first waveform half-bit waits for the next tick.

Optional Feature:
- Macro: PILOT_TONE_EN.
- Defined: `trext` is sampled at start acceptance. If it was 1, the PILOT state precedes PREAMBLE.
- Undefined:
  - The PILOT state and its counter are not built.
  - `trext` is ignored; the port remains.
  - Frames always begin with PREAMBLE.

Decomposition:
- Package `rfid_tx_pkg` holds:
  - the state enum typedef
  - PREAMBLE_HALVES = 12'b110100100011
  - PREAMBLE_LEN = 12
  - PILOT_HALVES = 24
- Sub-module `half_bit_tick`: clk_div sampling and edge detection. Inputs are clock, reset, clk_div; output is tick; reset level of its register is 1.

Test Plan:
- bit_count=0, divider at 9 → tx_out halves `110100100011` then `00`; tx_en high for 140 clocks; done pulses once; busy falls with it.
- data_in=4'b1010, bit_count=4 → preamble, then halves `00 10 11 01`, then dummy `00`; tx_en high for 220 clocks.
- start re-pulsed mid-DATA with different data_in → ignored; waveform identical to the original capture; single done pulse.
- reset asserted during DATA → next clock busy=tx_en=tx_out=0 with no done pulse; a following start (bit_count=0) produces the full frame from the first case.
- divider enable low for 50 clocks mid-PREAMBLE → tx_out frozen for 50 clocks, then the remaining halves resume unchanged.
- PILOT_TONE_EN defined, trext=1, bit_count=0 → 24 alternating halves starting H, then the preamble and dummy; tx_en high for 380 clocks. With the macro undefined, the same stimulus gives 140 clocks.

Source files
------------

// File: rtl/rfid_tx_pkg.sv
// Shared types and framing constants for the tag uplink FM0 encoder.
package rfid_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StPilot,
    StPreamble,
    StData,
    StDummy
  } state_e;

  localparam logic [11:0] PREAMBLE_HALVES = 12'b110100100011;
  localparam int unsigned PREAMBLE_LEN    = 12;
  localparam int unsigned PILOT_HALVES    = 24;

  // Preamble is sent MSB first; idx counts half-bits already emitted.
  function automatic logic preamble_half(input logic [3:0] idx);
    return PREAMBLE_HALVES[4'(PREAMBLE_LEN - 1) - idx];
  endfunction

endpackage

// File: rtl/half_bit_tick.sv
// Registers the divider output and flags every edge of it as one half-bit tick.
module half_bit_tick (
  input  logic clock,
  input  logic reset,
  input  logic clk_div,
  output logic tick
);

  logic clk_div_q, clk_div_d;

  always_comb begin
    clk_div_d = clk_div;
  end

  // Reset level matches the divider so no tick fires straight out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_div_q <= 1'b1;
    end else begin
      clk_div_q <= clk_div_d;
    end
  end

  assign tick = (clk_div != clk_div_q);

endmodule

// File: rtl/fm0_encoder.sv
// FM0 backscatter frame encoder: [pilot] + preamble + MSB-first data + dummy-1.
// Define PILOT_TONE_EN to build the optional pilot tone selected by trext.
module fm0_encoder
  import rfid_tx_pkg::*;
#(
  parameter int unsigned MAX_BITS = 32,
  parameter int unsigned CNT_W    = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clk_div,
  input  logic                start,
  input  logic [MAX_BITS-1:0] data_in,
  input  logic [CNT_W-1:0]    bit_count,
  input  logic                trext,
  output logic                busy,
  output logic                tx_en,
  output logic                tx_out,
  output logic                done
);

`ifdef PILOT_TONE_EN
  localparam int unsigned HalfW = 5;
`else
  localparam int unsigned HalfW = 4;
`endif

  logic tick;

  half_bit_tick u_half_bit_tick (
    .clock   (clock),
    .reset   (reset),
    .clk_div (clk_div),
    .tick    (tick)
  );

  state_e              state_q, state_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [CNT_W-1:0]    bits_q, bits_d;
  logic [HalfW-1:0]    half_cnt_q, half_cnt_d;
  logic                phase_q, phase_d;
  logic                busy_q, busy_d;
  logic                tx_en_q, tx_en_d;
  logic                tx_out_q, tx_out_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_clamped;

`ifdef PILOT_TONE_EN
  logic pilot_q, pilot_d;
`else
  logic unused_trext;
  assign unused_trext = trext;
`endif

  always_comb begin
    cnt_clamped = bit_count;
    if (bit_count > CNT_W'(MAX_BITS)) begin
      cnt_clamped = CNT_W'(MAX_BITS);
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    bits_d     = bits_q;
    half_cnt_d = half_cnt_q;
    phase_d    = phase_q;
    busy_d     = busy_q;
    tx_en_d    = tx_en_q;
    tx_out_d   = tx_out_q;
    done_d     = 1'b0;
`ifdef PILOT_TONE_EN
    pilot_d    = pilot_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Left-align the payload so the next bit to send is always the MSB.
          data_d  = data_in << (CNT_W'(MAX_BITS) - cnt_clamped);
          bits_d  = cnt_clamped;
          busy_d  = 1'b1;
          state_d = StWait;
`ifdef PILOT_TONE_EN
          pilot_d = trext;
`endif
        end
      end

      StWait: begin
        if (tick) begin
          tx_en_d    = 1'b1;
          half_cnt_d = HalfW'(1);
          state_d    = StPreamble;
          tx_out_d   = preamble_half(4'd0);
`ifdef PILOT_TONE_EN
          if (pilot_q) begin
            state_d  = StPilot;
            tx_out_d = 1'b1;
          end
`endif
        end
      end

`ifdef PILOT_TONE_EN
      StPilot: begin
        if (tick) begin
          if (half_cnt_q < HalfW'(PILOT_HALVES)) begin
            tx_out_d   = ~tx_out_q;
            half_cnt_d = half_cnt_q + HalfW'(1);
          end else begin
            state_d    = StPreamble;
            half_cnt_d = HalfW'(1);
            tx_out_d   = preamble_half(4'd0);
          end
        end
      end
`endif

      StPreamble: begin
        if (tick) begin
          if (half_cnt_q < HalfW'(PREAMBLE_LEN)) begin
            tx_out_d   = preamble_half(half_cnt_q[3:0]);
            half_cnt_d = half_cnt_q + HalfW'(1);
          end else begin
            tx_out_d = ~tx_out_q;
            phase_d  = 1'b0;
            state_d  = (bits_q == '0) ? StDummy : StData;
          end
        end
      end

      StData: begin
        if (tick) begin
          if (!phase_q) begin
            // Second half: a data-0 inverts mid-bit, a data-1 holds.
            tx_out_d = data_q[MAX_BITS-1] ? tx_out_q : ~tx_out_q;
            phase_d  = 1'b1;
          end else begin
            data_d   = {data_q[MAX_BITS-2:0], 1'b0};
            bits_d   = bits_q - CNT_W'(1);
            tx_out_d = ~tx_out_q;
            phase_d  = 1'b0;
            if (bits_q == CNT_W'(1)) begin
              state_d = StDummy;
            end
          end
        end
      end

      StDummy: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            done_d   = 1'b1;
            busy_d   = 1'b0;
            tx_en_d  = 1'b0;
            tx_out_d = 1'b0;
            state_d  = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      bits_q     <= '0;
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
      busy_q     <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_out_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef PILOT_TONE_EN
      pilot_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      bits_q     <= bits_d;
      half_cnt_q <= half_cnt_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      tx_en_q    <= tx_en_d;
      tx_out_q   <= tx_out_d;
      done_q     <= done_d;
`ifdef PILOT_TONE_EN
      pilot_q    <= pilot_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign tx_en  = tx_en_q;
  assign tx_out = tx_out_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fm0_encoder.sv
// Randomised bench for fm0_encoder against a half-bit sequence model of the FM0 frame.
module tb_fm0_encoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clk_div = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data_in = '0;
  logic [5:0]  bit_count = '0;
  logic        trext = 1'b0;
  logic        busy, tx_en, tx_out, done;

  fm0_encoder #(
    .MAX_BITS (32),
    .CNT_W    (6)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clk_div   (clk_div),
    .start     (start),
    .data_in   (data_in),
    .bit_count (bit_count),
    .trext     (trext),
    .busy      (busy),
    .tx_en     (tx_en),
    .tx_out    (tx_out),
    .done      (done)
  );

  always #5 clock = ~clock;

  int   n_total = 0;
  int   n_bad   = 0;
  logic obs[$];
  logic div_en   = 1'b1;
  logic div_reg  = 1'b1;
  int   div_cnt  = 0;
  int   en_cnt, done_cnt, glitches;
  logic last_out = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample DUT just after the edge, then advance the divider model.
  task automatic cyc();
    logic tick;
    @(posedge clock);
    #1;
    tick = (clk_div != div_reg);
    div_reg = reset ? 1'b1 : clk_div;
    if (!reset) begin
      if (tick && tx_en) obs.push_back(tx_out);
      if (!tick && (tx_out != last_out)) glitches++;
    end
    last_out = tx_out;
    if (tx_en) en_cnt++;
    if (done) done_cnt++;
    if (reset) begin
      div_cnt = 0;
      clk_div = 1'b1;
    end else if (div_en) begin
      if (div_cnt == 9) begin
        div_cnt = 0;
        clk_div = ~clk_div;
      end else begin
        div_cnt++;
      end
    end
  endtask

  function automatic void build_exp(input logic [31:0] d, input int cnt, input logic pil,
                                    output logic [127:0] v, output int len);
    logic lvl;
    int   eff;
    logic [11:0] pre;
    pre = 12'b110100100011;
    eff = (cnt > 32) ? 32 : cnt;
    v = '0;
    len = 0;
    if (pil) begin
      for (int i = 0; i < 24; i++) begin
        v = {v[126:0], ~logic'(i % 2)};
        len++;
      end
    end
    for (int i = 11; i >= 0; i--) begin
      v = {v[126:0], pre[i]};
      len++;
    end
    lvl = 1'b1;
    for (int i = eff - 1; i >= 0; i--) begin
      lvl = ~lvl;
      v = {v[126:0], lvl};
      if (!d[i]) lvl = ~lvl;
      v = {v[126:0], lvl};
      len += 2;
    end
    lvl = ~lvl;
    v = {v[126:0], lvl, lvl};
    len += 2;
  endfunction

  function automatic logic [127:0] obs_vec();
    logic [127:0] v;
    v = '0;
    foreach (obs[i]) v = {v[126:0], obs[i]};
    return v;
  endfunction

  task automatic start_frame(input logic [31:0] d, input logic [5:0] cnt, input logic tx);
    obs = {};
    en_cnt = 0;
    done_cnt = 0;
    glitches = 0;
    data_in = d;
    bit_count = cnt;
    trext = tx;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_eq("busy_on_start", busy, 1'b1);
    data_in = $urandom;
    bit_count = 6'($urandom);
    trext = 1'($urandom);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] d, input logic [5:0] cnt,
                           input logic tx, input int restart_at, input int stall_at,
                           input int en_exp);
    logic [127:0] ev;
    int   len, stall_clk;
    logic pil, restarted, stalled, frozen, busy_at_done, en_at_done;
    bit   finished;
`ifdef PILOT_TONE_EN
    pil = tx;
`else
    pil = 1'b0;
`endif
    build_exp(d, int'(cnt), pil, ev, len);
    restarted = 1'b0;
    stalled = 1'b0;
    stall_clk = 0;
    finished = 1'b0;
    busy_at_done = 1'b1;
    en_at_done = 1'b1;
    start_frame(d, cnt, tx);
    for (int k = 0; k < 4000 && !finished; k++) begin
      cyc();
      start = 1'b0;
      if (done_cnt > 0) begin
        finished = 1'b1;
        busy_at_done = busy;
        en_at_done = tx_en;
      end else if (!restarted && restart_at >= 0 && obs.size() == restart_at) begin
        restarted = 1'b1;
        start = 1'b1;
        data_in = ~d;
        bit_count = 6'd5;
        trext = ~tx;
      end else if (!stalled && stall_at >= 0 && obs.size() == stall_at) begin
        stalled = 1'b1;
        div_en = 1'b0;
        frozen = tx_out;
        repeat (50) begin
          cyc();
          if (tx_out != frozen) stall_clk++;
        end
        check_eq({tag, "_stall_frozen"}, stall_clk, 0);
        div_en = 1'b1;
      end
    end
    check_eq({tag, "_finished"}, finished, 1'b1);
    check_eq({tag, "_halves_len"}, obs.size(), len);
    check_eq({tag, "_halves"}, obs_vec(), ev);
    check_eq({tag, "_busy_at_done"}, busy_at_done, 1'b0);
    check_eq({tag, "_en_at_done"}, en_at_done, 1'b0);
    check_eq({tag, "_glitches"}, glitches, 0);
    if (en_exp >= 0) check_eq({tag, "_en_clocks"}, en_cnt, en_exp);
    else check_eq({tag, "_en_clocks"}, en_cnt, 10 * len + (stalled ? 50 : 0));
    cyc();
    check_eq({tag, "_done_once"}, {done, done_cnt[7:0]}, {1'b0, 8'd1});
    check_eq({tag, "_idle_out"}, {busy, tx_en, tx_out}, 3'b000);
  endtask

  initial begin
    logic [31:0] d;
    int pil_len;
    repeat (4) cyc();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_tx_en", tx_en, 1'b0);
    check_eq("rst_tx_out", tx_out, 1'b0);
    check_eq("rst_done", done, 1'b0);
    reset = 1'b0;
    repeat (7) cyc();
    check_eq("idle_no_tick_out", {busy, tx_en, tx_out, done}, 4'b0000);

    run_frame("cnt0", 32'h0, 6'd0, 1'b0, -1, -1, 140);
    repeat (3) cyc();
    run_frame("d1010", 32'h0000_000A, 6'd4, 1'b0, -1, -1, 220);
    repeat (5) cyc();
    run_frame("restart", 32'h0000_00B4, 6'd8, 1'b0, 15, -1, -1);
    repeat (2) cyc();
    run_frame("stall", 32'h0000_0003, 6'd2, 1'b0, -1, 5, -1);

    // Reset while in DATA, then a clean bit_count=0 frame.
    start_frame(32'hDEAD_BEEF, 6'd16, 1'b0);
    for (int k = 0; k < 2000 && obs.size() < 20; k++) cyc();
    check_eq("rstmid_reached_data", obs.size(), 20);
    reset = 1'b1;
    cyc();
    check_eq("rstmid_outs", {busy, tx_en, tx_out, done}, 4'b0000);
    reset = 1'b0;
    done_cnt = 0;
    repeat (30) cyc();
    check_eq("rstmid_no_done", {done_cnt[7:0], busy}, 9'd0);
    run_frame("after_rst", 32'h0, 6'd0, 1'b0, -1, -1, 140);

`ifdef PILOT_TONE_EN
    pil_len = 380;
`else
    pil_len = 140;
`endif
    run_frame("pilot", 32'h0, 6'd0, 1'b1, -1, -1, pil_len);
    run_frame("clamp63", 32'h8000_0001, 6'd63, 1'b0, -1, -1, -1);

    for (int n = 0; n < 8; n++) begin
      d = $urandom;
      repeat ($urandom_range(0, 15)) cyc();
      run_frame("rand", d, 6'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
